// File: rtl/dot11_fcs_pkg.sv
// Shared constants and types for the dot11 FCS checker.
// Optional payload pass-through is enabled by DOT11_FCS_PASS_EN.
package dot11_fcs_pkg;

  localparam logic [31:0] CRC32_POLY_R  = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam int FCS_BYTES = 4;
  localparam int MIN_PSDU  = 5;

  typedef enum logic [1:0] {
    FCS_IDLE,
    FCS_RUN,
    FCS_DONE
  } fcs_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update, one byte per call, LSB first.
// Shared between the RX FCS checker and the TX FCS generator.
module crc32_d8
  import dot11_fcs_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      if (crc_next[0])
        crc_next = (crc_next >> 1) ^ CRC32_POLY_R;
      else
        crc_next = crc_next >> 1;
    end
  end

endmodule

// File: rtl/dot11_fcs_check.sv
// Checks the 802.11 FCS over a decoded PSDU byte stream.
// DOT11_FCS_PASS_EN adds an FCS-stripping payload pass-through.
module dot11_fcs_check
  import dot11_fcs_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [7:0]       byte_in,
  input  logic             byte_in_strobe,
  output logic             busy,
  output logic [LEN_W-1:0] byte_count,
  output logic             fcs_out_strobe,
  output logic             fcs_ok,
  output logic             len_err
`ifdef DOT11_FCS_PASS_EN
  ,
  output logic [7:0]       payload_byte,
  output logic             payload_strobe,
  output logic             payload_last
`endif
);

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_PSDU);

  fcs_state_t       state;
  fcs_state_t       state_nxt;
  logic [31:0]      crc_q;
  logic [31:0]      crc_nxt;
  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] count_inc;
  logic [LEN_W-1:0] len_q;
  logic             short_len;
  logic             acc;
  logic             last_byte;

  crc32_d8 u_crc (
    .crc      (crc_q),
    .data     (byte_in),
    .crc_next (crc_nxt)
  );

  assign short_len = pkt_len < MIN_LEN;
  assign count_inc = (&count_q) ? count_q : count_q + 1'b1;
  assign acc       = enable && !start && byte_in_strobe
                   && (state == FCS_RUN);
  assign last_byte = acc && (count_inc == len_q);

  always_ff @(posedge clock) begin
    if (reset)
      state <= FCS_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (enable) begin
      if (start) begin
        state_nxt = short_len ? FCS_DONE : FCS_RUN;
      end else begin
        unique case (1'b1)
          state == FCS_IDLE: state_nxt = FCS_IDLE;
          state == FCS_RUN:
            if (last_byte) state_nxt = FCS_DONE;
          state == FCS_DONE: state_nxt = FCS_IDLE;
          default:           state_nxt = FCS_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      crc_q   <= CRC32_INIT;
      count_q <= '0;
      len_q   <= '0;
      fcs_ok  <= 1'b0;
      len_err <= 1'b0;
    end else if (enable) begin
      if (start) begin
        crc_q   <= CRC32_INIT;
        count_q <= '0;
        len_q   <= pkt_len;
        fcs_ok  <= 1'b0;
        len_err <= short_len;
      end else if (acc) begin
        crc_q   <= crc_nxt;
        count_q <= count_inc;
        if (last_byte)
          fcs_ok <= (crc_nxt == CRC32_RESIDUE);
      end
    end
  end

  // Strobe is gated so a stalled DONE cycle still yields one pulse.
  always_comb begin
    busy           = (state == FCS_RUN);
    byte_count     = count_q;
    fcs_out_strobe = (state == FCS_DONE) && enable;
  end

`ifdef DOT11_FCS_PASS_EN
  logic [7:0] dly [FCS_BYTES];
  logic       pay_stb_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FCS_BYTES; i++)
        dly[i] <= 8'd0;
      payload_byte <= 8'd0;
      pay_stb_q    <= 1'b0;
      payload_last <= 1'b0;
    end else if (enable) begin
      pay_stb_q    <= 1'b0;
      payload_last <= 1'b0;
      if (start) begin
        for (int i = 0; i < FCS_BYTES; i++)
          dly[i] <= 8'd0;
      end else if (acc) begin
        dly[0] <= byte_in;
        for (int i = 1; i < FCS_BYTES; i++)
          dly[i] <= dly[i-1];
        // Oldest byte leaves only once four newer bytes exist.
        if (count_q >= LEN_W'(FCS_BYTES)) begin
          payload_byte <= dly[FCS_BYTES-1];
          pay_stb_q    <= 1'b1;
          payload_last <= last_byte;
        end
      end
    end
  end

  assign payload_strobe = pay_stb_q && enable;
`endif

endmodule

// File: tb/tb_dot11_fcs_check.sv
// Directed self-checking bench for dot11_fcs_check.
// Pass-through checks are built when DOT11_FCS_PASS_EN is defined.
module tb_dot11_fcs_check;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic [15:0] pkt_len;
  logic [7:0]  byte_in;
  logic        byte_in_strobe;
  logic        busy;
  logic [15:0] byte_count;
  logic        fcs_out_strobe;
  logic        fcs_ok;
  logic        len_err;
`ifdef DOT11_FCS_PASS_EN
  logic [7:0]  payload_byte;
  logic        payload_strobe;
  logic        payload_last;
`endif

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;

  logic [7:0] vec [13] = '{
    8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
    8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB
  };

  dot11_fcs_check #(.LEN_W(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .start          (start),
    .pkt_len        (pkt_len),
    .byte_in        (byte_in),
    .byte_in_strobe (byte_in_strobe),
    .busy           (busy),
    .byte_count     (byte_count),
    .fcs_out_strobe (fcs_out_strobe),
    .fcs_ok         (fcs_ok),
    .len_err        (len_err)
`ifdef DOT11_FCS_PASS_EN
    ,
    .payload_byte   (payload_byte),
    .payload_strobe (payload_strobe),
    .payload_last   (payload_last)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (fcs_out_strobe) strobe_cnt <= strobe_cnt + 1;

`ifdef DOT11_FCS_PASS_EN
  logic [7:0] pq [$];
  int         last_idx = -1;
  always @(posedge clock) begin
    if (payload_strobe) begin
      pq.push_back(payload_byte);
      if (payload_last) last_idx = pq.size() - 1;
    end
  end
`endif

  task automatic cyc(input logic st, input logic [7:0] b);
    byte_in_strobe = st;
    byte_in = b;
    @(negedge clock);
    byte_in_strobe = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] len);
    start = 1'b1;
    pkt_len = len;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (byte_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", byte_count); end
    checks++; if (fcs_out_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b want 0", fcs_out_strobe); end
    checks++; if (fcs_ok !== 1'b0) begin errors++; $display("FAIL rst_ok: got %b want 0", fcs_ok); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL rst_len_err: got %b want 0", len_err); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_good_frame;
    int s0;
    s0 = strobe_cnt;
    do_start(16'd13);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy: got %b want 1", busy); end
    for (int i = 0; i < 12; i++) cyc(1'b1, vec[i]);
    checks++; if (fcs_out_strobe !== 1'b0) begin errors++; $display("FAIL good_early_strobe: got %b want 0", fcs_out_strobe); end
    checks++; if (byte_count !== 16'd12) begin errors++; $display("FAIL good_count12: got %0d want 12", byte_count); end
    cyc(1'b1, vec[12]);
    checks++; if (fcs_out_strobe !== 1'b1) begin errors++; $display("FAIL good_strobe: got %b want 1", fcs_out_strobe); end
    checks++; if (fcs_ok !== 1'b1) begin errors++; $display("FAIL good_ok: got %b want 1", fcs_ok); end
    checks++; if (byte_count !== 16'd13) begin errors++; $display("FAIL good_count: got %0d want 13", byte_count); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL good_len_err: got %b want 0", len_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_done: got %b want 0", busy); end
    cyc(1'b0, 8'h00);
    checks++; if (fcs_out_strobe !== 1'b0) begin errors++; $display("FAIL good_strobe_width: got %b want 0", fcs_out_strobe); end
    checks++; if (fcs_ok !== 1'b1) begin errors++; $display("FAIL good_ok_held: got %b want 1", fcs_ok); end
    checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL good_nstrobe: got %0d want 1", strobe_cnt - s0); end
  endtask

  task automatic test_short_len;
    int s0;
    s0 = strobe_cnt;
    do_start(16'd4);
    checks++; if (fcs_out_strobe !== 1'b1) begin errors++; $display("FAIL short_strobe: got %b want 1", fcs_out_strobe); end
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL short_len_err: got %b want 1", len_err); end
    checks++; if (fcs_ok !== 1'b0) begin errors++; $display("FAIL short_ok: got %b want 0", fcs_ok); end
    for (int i = 0; i < 3; i++) cyc(1'b1, vec[i]);
    checks++; if (byte_count !== 16'd0) begin errors++; $display("FAIL short_count: got %0d want 0", byte_count); end
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL short_len_err_held: got %b want 1", len_err); end
    checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL short_nstrobe: got %0d want 1", strobe_cnt - s0); end
  endtask

  task automatic test_bad_fcs;
    do_start(16'd13);
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL bad_len_err_clr: got %b want 0", len_err); end
    for (int i = 0; i < 12; i++) cyc(1'b1, vec[i]);
    cyc(1'b1, 8'hCA);
    checks++; if (fcs_out_strobe !== 1'b1) begin errors++; $display("FAIL bad_strobe: got %b want 1", fcs_out_strobe); end
    checks++; if (fcs_ok !== 1'b0) begin errors++; $display("FAIL bad_ok: got %b want 0", fcs_ok); end
    checks++; if (byte_count !== 16'd13) begin errors++; $display("FAIL bad_count: got %0d want 13", byte_count); end
    cyc(1'b0, 8'h00);
  endtask

  task automatic test_abort;
    int s0;
    s0 = strobe_cnt;
    do_start(16'd13);
    for (int i = 0; i < 6; i++) cyc(1'b1, vec[i]);
    start = 1'b1;
    pkt_len = 16'd13;
    byte_in_strobe = 1'b1;
    byte_in = 8'h55;
    @(negedge clock);
    start = 1'b0;
    byte_in_strobe = 1'b0;
    checks++; if (byte_count !== 16'd0) begin errors++; $display("FAIL abort_count: got %0d want 0", byte_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b want 1", busy); end
    for (int i = 0; i < 13; i++) cyc(1'b1, vec[i]);
    checks++; if (fcs_ok !== 1'b1) begin errors++; $display("FAIL abort_ok: got %b want 1", fcs_ok); end
    checks++; if (byte_count !== 16'd13) begin errors++; $display("FAIL abort_count_end: got %0d want 13", byte_count); end
    cyc(1'b0, 8'h00);
    checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL abort_nstrobe: got %0d want 1", strobe_cnt - s0); end
  endtask

  task automatic test_enable;
    do_start(16'd13);
    for (int i = 0; i < 5; i++) cyc(1'b1, vec[i]);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, vec[5]);
    checks++; if (byte_count !== 16'd5) begin errors++; $display("FAIL en_hold_count: got %0d want 5", byte_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_hold_busy: got %b want 1", busy); end
    enable = 1'b1;
    for (int i = 6; i < 13; i++) cyc(1'b1, vec[i]);
    checks++; if (fcs_out_strobe !== 1'b0) begin errors++; $display("FAIL en_drop_early: got %b want 0", fcs_out_strobe); end
    cyc(1'b1, 8'h00);
    checks++; if (fcs_out_strobe !== 1'b1) begin errors++; $display("FAIL en_drop_strobe: got %b want 1", fcs_out_strobe); end
    checks++; if (fcs_ok !== 1'b0) begin errors++; $display("FAIL en_drop_ok: got %b want 0", fcs_ok); end
    cyc(1'b0, 8'h00);
    do_start(16'd13);
    for (int i = 0; i < 5; i++) cyc(1'b1, vec[i]);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00);
    enable = 1'b1;
    for (int i = 5; i < 13; i++) cyc(1'b1, vec[i]);
    checks++; if (fcs_out_strobe !== 1'b1) begin errors++; $display("FAIL en_gap_strobe: got %b want 1", fcs_out_strobe); end
    checks++; if (fcs_ok !== 1'b1) begin errors++; $display("FAIL en_gap_ok: got %b want 1", fcs_ok); end
    checks++; if (byte_count !== 16'd13) begin errors++; $display("FAIL en_gap_count: got %0d want 13", byte_count); end
    cyc(1'b0, 8'h00);
  endtask

`ifdef DOT11_FCS_PASS_EN
  task automatic test_pass;
    int s0;
    pq.delete();
    last_idx = -1;
    do_start(16'd13);
    for (int i = 0; i < 12; i++) cyc(1'b1, vec[i]);
    cyc(1'b1, vec[12]);
    checks++; if (payload_last !== 1'b1 || payload_strobe !== 1'b1 || fcs_out_strobe !== 1'b1) begin errors++; $display("FAIL pass_last_align: got last=%b stb=%b fcs=%b want 1 1 1", payload_last, payload_strobe, fcs_out_strobe); end
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    checks++; if (pq.size() !== 9) begin errors++; $display("FAIL pass_nbytes: got %0d want 9", pq.size()); end
    for (int i = 0; i < 9 && i < pq.size(); i++) begin
      checks++; if (pq[i] !== vec[i]) begin errors++; $display("FAIL pass_byte%0d: got %h want %h", i, pq[i], vec[i]); end
    end
    checks++; if (last_idx !== 8) begin errors++; $display("FAIL pass_last_idx: got %0d want 8", last_idx); end
    pq.delete();
    s0 = strobe_cnt;
    do_start(16'd13);
    for (int i = 0; i < 6; i++) cyc(1'b1, vec[i]);
    reset = 1'b1;
    cyc(1'b1, vec[6]);
    reset = 1'b0;
    checks++; if (payload_strobe !== 1'b0) begin errors++; $display("FAIL pass_rst_strobe: got %b want 0", payload_strobe); end
    for (int i = 7; i < 13; i++) cyc(1'b1, vec[i]);
    cyc(1'b0, 8'h00);
    checks++; if (pq.size() !== 2) begin errors++; $display("FAIL pass_rst_nbytes: got %0d want 2", pq.size()); end
    checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL pass_rst_nstrobe: got %0d want 0", strobe_cnt - s0); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    start = 1'b0;
    pkt_len = 16'd0;
    byte_in = 8'h00;
    byte_in_strobe = 1'b0;
    @(negedge clock);
    test_reset();
    test_good_frame();
    test_short_len();
    test_bad_fcs();
    test_abort();
    test_enable();
`ifdef DOT11_FCS_PASS_EN
    test_pass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
